// File: rtl/shapool_pkg.sv
// rtl/shapool_pkg.sv - shared types and constants for the shapool job controller
//
// Holds the controller state enum, the pool round count and the packed job
// record that is captured on accept and presented to the pool.
package shapool_pkg;

    localparam int ROUNDS = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } state_t;

    typedef struct packed {
        logic [255:0] sha_state;
        logic [95:0]  message_head;
        logic [15:0]  difficulty_bm;
        logic [7:0]   nonce_start_MSB;
    } job_t;

endpackage

// File: rtl/shapool_job_ctrl_if.sv
// rtl/shapool_job_ctrl_if.sv - job and result handshakes of the shapool job controller
//
// master : host side, offers jobs and consumes result records.
// slave  : controller side.
// Job channel    : job_valid/job_ready plus sha_state, message_head,
//                  difficulty_bm and nonce_start_MSB fields.
// Result channel : result_valid/result_ready plus found flag and nonce.
interface shapool_job_ctrl_if #(
    parameter int NONCE_WIDTH = 32
);
    logic                   job_valid;
    logic                   job_ready;
    logic [255:0]           job_sha_state;
    logic [95:0]            job_message_head;
    logic [15:0]            job_difficulty_bm;
    logic [7:0]             job_nonce_start_MSB;
    logic                   result_valid;
    logic                   result_ready;
    logic                   result_found;
    logic [NONCE_WIDTH-1:0] result_nonce;

    modport master (
        output job_valid, job_sha_state, job_message_head, job_difficulty_bm,
               job_nonce_start_MSB, result_ready,
        input  job_ready, result_valid, result_found, result_nonce
    );

    modport slave (
        input  job_valid, job_sha_state, job_message_head, job_difficulty_bm,
               job_nonce_start_MSB, result_ready,
        output job_ready, result_valid, result_found, result_nonce
    );
endinterface

// File: rtl/shapool_scan_timer.sv
// rtl/shapool_scan_timer.sv - round phase and scan period tracking for one job
//
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clr        : zero phase and period count (job start)
//   en         : advance one round (pool running)
//   exhausted  : this enabled cycle is the last round of the final period
module shapool_scan_timer
    import shapool_pkg::*;
#(
    parameter int SCAN_LOG2 = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic exhausted
);
    localparam int PW = SCAN_LOG2 + 2;
    localparam logic [5:0] LAST_PHASE = 6'(ROUNDS - 1);
    // The scan ends on the wrap that brings the period count to 2^SCAN_LOG2+2,
    // so the final period is the one whose count is 2^SCAN_LOG2+1.
    localparam logic [PW-1:0] LAST_PERIOD = PW'((1 << SCAN_LOG2) + 1);

    logic [5:0]    phase;
    logic [PW-1:0] period;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            phase  <= '0;
            period <= '0;
        end else if (en) begin
            phase <= phase + 1'b1;
            if (phase == LAST_PHASE) begin
                period <= period + 1'b1;
            end
        end
    end

    assign exhausted = en && (phase == LAST_PHASE) && (period == LAST_PERIOD);

endmodule

// File: rtl/shapool_job_ctrl.sv
// rtl/shapool_job_ctrl.sv - job sequencer in front of the shapool hashing pool
//
// Accepts one job, holds its fields on pool_*, pulses pool_reset_n low for
// RESET_CYCLES, runs the pool until a match or slice exhaustion, then offers a
// single result record.
// Ports:
//   clk, reset           : clock and synchronous active-high reset
//   host (slave)         : job valid/ready + fields, result valid/ready + record
//   abort                : cancel the job in LOAD or RUN
//   pool_reset_n         : active-low pool reset, high only while running
//   pool_sha_state, pool_message_head, pool_difficulty_bm,
//   pool_nonce_start_MSB : captured job fields
//   pool_success         : pool match flag
//   pool_nonce           : pool nonce counter
//   busy                 : controller is not idle
module shapool_job_ctrl
    import shapool_pkg::*;
#(
    parameter int NONCE_WIDTH  = 32,
    parameter int SCAN_LOG2    = 24,
    parameter int RESET_CYCLES = 2,
    parameter int NONCE_LAG    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    shapool_job_ctrl_if.slave      host,
    input  logic                   abort,
    output logic                   pool_reset_n,
    output logic [255:0]           pool_sha_state,
    output logic [95:0]            pool_message_head,
    output logic [15:0]            pool_difficulty_bm,
    output logic [7:0]             pool_nonce_start_MSB,
    input  logic                   pool_success,
    input  logic [NONCE_WIDTH-1:0] pool_nonce,
    output logic                   busy
);
    localparam int LCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [LCW-1:0] LOAD_LAST = LCW'(RESET_CYCLES - 1);

    state_t                 state;
    job_t                   job_q;
    logic [LCW-1:0]         load_cnt;
    // Cleared by reset and set one cycle later, so job_ready stays low for the
    // first cycle out of reset even though the state is already IDLE.
    logic                   armed;
    logic                   result_valid_q;
    logic                   result_found_q;
    logic [NONCE_WIDTH-1:0] result_nonce_q;
    logic                   accept;
    logic                   exhausted;

    assign host.job_ready    = (state == IDLE) && armed;
    assign accept            = host.job_valid && host.job_ready;
    assign host.result_valid = result_valid_q;
    assign host.result_found = result_found_q;
    assign host.result_nonce = result_nonce_q;

    assign pool_sha_state       = job_q.sha_state;
    assign pool_message_head    = job_q.message_head;
    assign pool_difficulty_bm   = job_q.difficulty_bm;
    assign pool_nonce_start_MSB = job_q.nonce_start_MSB;

    shapool_scan_timer #(
        .SCAN_LOG2 (SCAN_LOG2)
    ) u_scan_timer (
        .clk       (clk),
        .reset     (reset),
        .clr       (accept),
        .en        (state == RUN),
        .exhausted (exhausted)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            armed          <= 1'b0;
            job_q          <= '0;
            load_cnt       <= '0;
            pool_reset_n   <= 1'b0;
            busy           <= 1'b0;
            result_valid_q <= 1'b0;
            result_found_q <= 1'b0;
            result_nonce_q <= '0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        job_q    <= '{sha_state:       host.job_sha_state,
                                      message_head:    host.job_message_head,
                                      difficulty_bm:   host.job_difficulty_bm,
                                      nonce_start_MSB: host.job_nonce_start_MSB};
                        load_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (load_cnt == LOAD_LAST) begin
                        pool_reset_n <= 1'b1;
                        state        <= RUN;
                    end else begin
                        load_cnt <= load_cnt + 1'b1;
                    end
                end
                RUN: begin
                    // abort beats success, success beats exhaustion
                    if (abort) begin
                        pool_reset_n <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else if (pool_success) begin
                        pool_reset_n   <= 1'b0;
                        result_valid_q <= 1'b1;
                        result_found_q <= 1'b1;
                        // pool_nonce has run ahead of the matching nonce by NONCE_LAG
                        result_nonce_q <= pool_nonce - NONCE_WIDTH'(NONCE_LAG);
                        state          <= REPORT;
                    end else if (exhausted) begin
                        pool_reset_n   <= 1'b0;
                        result_valid_q <= 1'b1;
                        result_found_q <= 1'b0;
                        result_nonce_q <= '0;
                        state          <= REPORT;
                    end
                end
                REPORT: begin
                    if (host.result_ready) begin
                        result_valid_q <= 1'b0;
                        busy           <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shapool_job_ctrl.sv
// tb/tb_shapool_job_ctrl.sv - self-checking bench for shapool_job_ctrl
module tb_shapool_job_ctrl;
    localparam int NW      = 32;
    localparam int SL      = 2;
    localparam int RC      = 2;
    localparam int LAG     = 2;
    localparam int EXH_LEN = 64 * ((1 << SL) + 2);

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           abort = 1'b0;
    logic           pool_success = 1'b0;
    logic [NW-1:0]  pool_nonce = '0;
    logic           pool_reset_n;
    logic [255:0]   pool_sha_state;
    logic [95:0]    pool_message_head;
    logic [15:0]    pool_difficulty_bm;
    logic [7:0]     pool_nonce_start_MSB;
    logic           busy;

    shapool_job_ctrl_if #(.NONCE_WIDTH(NW)) host_if ();

    shapool_job_ctrl #(
        .NONCE_WIDTH  (NW),
        .SCAN_LOG2    (SL),
        .RESET_CYCLES (RC),
        .NONCE_LAG    (LAG)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .host                 (host_if),
        .abort                (abort),
        .pool_reset_n         (pool_reset_n),
        .pool_sha_state       (pool_sha_state),
        .pool_message_head    (pool_message_head),
        .pool_difficulty_bm   (pool_difficulty_bm),
        .pool_nonce_start_MSB (pool_nonce_start_MSB),
        .pool_success         (pool_success),
        .pool_nonce           (pool_nonce),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a job is described by its run start cycle and its
    // exhaustion deadline; outputs follow from where the current cycle lies.
    int            cyc = 0;
    int            k;
    bit            cmp_en = 1'b0;
    bit            m_active = 1'b0;
    bit            m_pending = 1'b0;
    bit            m_found = 1'b0;
    int            m_ready_at = 0;
    int            m_run_start = 0;
    logic [NW-1:0] m_nonce = '0;
    logic [255:0]  m_sha = '0;
    logic [95:0]   m_head = '0;
    logic [15:0]   m_diff = '0;
    logic [7:0]    m_msb = '0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 50)
                $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        k = cyc;
        if (reset) begin
            cmp_en     = 1'b1;
            m_active   = 1'b0;
            m_pending  = 1'b0;
            m_found    = 1'b0;
            m_nonce    = '0;
            m_sha      = '0;
            m_head     = '0;
            m_diff     = '0;
            m_msb      = '0;
            m_ready_at = k + 2;
        end else if (m_pending) begin
            if (host_if.result_ready) m_pending = 1'b0;
        end else if (m_active) begin
            if (abort) begin
                m_active = 1'b0;
            end else if (k >= m_run_start) begin
                if (pool_success) begin
                    m_active  = 1'b0;
                    m_pending = 1'b1;
                    m_found   = 1'b1;
                    m_nonce   = pool_nonce - NW'(LAG);
                end else if (k == m_run_start + EXH_LEN - 1) begin
                    m_active  = 1'b0;
                    m_pending = 1'b1;
                    m_found   = 1'b0;
                    m_nonce   = '0;
                end
            end
        end else if (k >= m_ready_at && host_if.job_valid) begin
            m_active    = 1'b1;
            m_sha       = host_if.job_sha_state;
            m_head      = host_if.job_message_head;
            m_diff      = host_if.job_difficulty_bm;
            m_msb       = host_if.job_nonce_start_MSB;
            m_run_start = k + RC + 1;
        end
        cyc = cyc + 1;
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("cmp_job_ready", host_if.job_ready,
                  !m_active && !m_pending && (cyc >= m_ready_at));
            check("cmp_busy", busy, m_active || m_pending);
            check("cmp_pool_reset_n", pool_reset_n, m_active && (cyc >= m_run_start));
            check("cmp_result_valid", host_if.result_valid, m_pending);
            check("cmp_pool_sha_state", pool_sha_state, m_sha);
            check("cmp_pool_message_head", pool_message_head, m_head);
            check("cmp_pool_difficulty_bm", pool_difficulty_bm, m_diff);
            check("cmp_pool_nonce_start_MSB", pool_nonce_start_MSB, m_msb);
            if (m_pending) begin
                check("cmp_result_found", host_if.result_found, m_found);
                check("cmp_result_nonce", host_if.result_nonce, m_nonce);
            end
        end
    end

    task automatic set_job(input logic [7:0] msb);
        host_if.job_sha_state       = {$urandom, $urandom, $urandom, $urandom,
                                       $urandom, $urandom, $urandom, $urandom};
        host_if.job_message_head    = {$urandom, $urandom, $urandom};
        host_if.job_difficulty_bm   = 16'($urandom);
        host_if.job_nonce_start_MSB = msb;
    endtask

    // Offer a job while idle and advance to the first RUN cycle.
    task automatic start_job(input logic [7:0] msb);
        set_job(msb);
        host_if.job_valid = 1'b1;
        step();
        host_if.job_valid = 1'b0;
        repeat (RC) step();
    endtask

    task automatic consume_result();
        host_if.result_ready = 1'b1;
        step();
        host_if.result_ready = 1'b0;
    endtask

    initial begin
        int n;
        host_if.job_valid    = 1'b0;
        host_if.result_ready = 1'b0;
        set_job(8'h00);

        reset = 1'b1;
        repeat (3) step();
        check("rst_job_ready", host_if.job_ready, 1'b0);
        check("rst_pool_reset_n", pool_reset_n, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_result_valid", host_if.result_valid, 1'b0);
        check("rst_result_found", host_if.result_found, 1'b0);
        check("rst_result_nonce", host_if.result_nonce, 32'h0);
        check("rst_pool_msb", pool_nonce_start_MSB, 8'h00);
        reset = 1'b0;
        step();
        check("ready_after_reset", host_if.job_ready, 1'b1);

        // Accept, LOAD length, found result held under backpressure
        set_job(8'h3A);
        host_if.job_valid = 1'b1;
        step();
        host_if.job_valid = 1'b0;
        check("accept_ready_drop", host_if.job_ready, 1'b0);
        check("accept_msb", pool_nonce_start_MSB, 8'h3A);
        check("load1_pool_reset_n", pool_reset_n, 1'b0);
        step();
        check("load2_pool_reset_n", pool_reset_n, 1'b0);
        step();
        check("run0_pool_reset_n", pool_reset_n, 1'b1);
        repeat (199) step();
        pool_success = 1'b1;
        pool_nonce   = 32'h3A000007;
        step();
        pool_success = 1'b0;
        check("found_valid", host_if.result_valid, 1'b1);
        check("found_flag", host_if.result_found, 1'b1);
        check("found_nonce", host_if.result_nonce, 32'h3A000005);
        check("report_pool_reset_n", pool_reset_n, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_valid", host_if.result_valid, 1'b1);
            check("hold_found", host_if.result_found, 1'b1);
            check("hold_nonce", host_if.result_nonce, 32'h3A000005);
        end
        consume_result();
        check("ready_after_handshake", host_if.job_ready, 1'b1);
        check("valid_after_handshake", host_if.result_valid, 1'b0);

        // Exhaustion latency
        start_job(8'h11);
        n = 0;
        while (!host_if.result_valid && n < 1000) begin
            step();
            n++;
        end
        check("exhaust_latency", n, 384);
        check("exhaust_found", host_if.result_found, 1'b0);
        check("exhaust_nonce", host_if.result_nonce, 32'h0);
        consume_result();

        // Abort during RUN, later success ignored
        start_job(8'h5C);
        repeat (100) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_job_ready", host_if.job_ready, 1'b1);
        check("abort_pool_reset_n", pool_reset_n, 1'b0);
        check("abort_result_valid", host_if.result_valid, 1'b0);
        check("abort_keeps_msb", pool_nonce_start_MSB, 8'h5C);
        pool_success = 1'b1;
        pool_nonce   = 32'h12345678;
        step();
        pool_success = 1'b0;
        check("late_success_valid", host_if.result_valid, 1'b0);
        check("late_success_busy", busy, 1'b0);

        // Success on the exhaustion boundary cycle
        start_job(8'hC7);
        repeat (383) step();
        pool_success = 1'b1;
        pool_nonce   = 32'hC7000100;
        step();
        pool_success = 1'b0;
        check("boundary_valid", host_if.result_valid, 1'b1);
        check("boundary_found", host_if.result_found, 1'b1);
        check("boundary_nonce", host_if.result_nonce, 32'hC70000FE);
        consume_result();

        // Reset mid-RUN, then immediate new job, then reset mid-REPORT
        start_job(8'h42);
        repeat (50) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_run_job_ready", host_if.job_ready, 1'b0);
        check("rst_run_busy", busy, 1'b0);
        check("rst_run_pool_reset_n", pool_reset_n, 1'b0);
        check("rst_run_msb", pool_nonce_start_MSB, 8'h00);
        step();
        check("rst_run_ready_back", host_if.job_ready, 1'b1);
        start_job(8'h43);
        check("rerun_busy", busy, 1'b1);
        check("rerun_msb", pool_nonce_start_MSB, 8'h43);
        repeat (130) step();
        pool_success = 1'b1;
        pool_nonce   = 32'h43000200;
        step();
        pool_success = 1'b0;
        check("rerun_valid", host_if.result_valid, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_rep_valid", host_if.result_valid, 1'b0);
        check("rst_rep_found", host_if.result_found, 1'b0);
        check("rst_rep_nonce", host_if.result_nonce, 32'h0);
        check("rst_rep_busy", busy, 1'b0);
        check("rst_rep_sha", pool_sha_state, 256'h0);
        step();
        check("rst_rep_ready_back", host_if.job_ready, 1'b1);

        // Randomized traffic against the model
        for (int c = 0; c < 20000; c++) begin
            set_job(8'($urandom));
            host_if.job_valid    = ($urandom_range(0, 3) == 0);
            abort                = ($urandom_range(0, 299) == 0);
            pool_success         = ($urandom_range(0, 199) == 0);
            pool_nonce           = $urandom;
            host_if.result_ready = ($urandom_range(0, 2) == 0);
            reset                = ($urandom_range(0, 4999) == 0);
            step();
        end
        host_if.job_valid    = 1'b0;
        abort                = 1'b0;
        pool_success         = 1'b0;
        host_if.result_ready = 1'b0;
        reset                = 1'b0;
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
